if_fetch_unit: RTL and testbench

- Instruction fetch stage that drives the decode stage's inputs: IF_PC, the decoded instruction fields and en.
- Consumes the decode stage's IF_flush/EA redirect and the hazard unit's stall.
- Owns the PC, a single-outstanding-request instruction-memory handshake, a one-entry hold buffer and the IF/ID pipeline register.
- Produces IF_flush_out so decode squashes the wrong-path slot.

---
 rtl/if_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, one-entry hold buffer and IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_cnt / flush_cnt performance counter outputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        IF_flush,
    input  logic        jump_ID,
    input  logic [31:0] EA,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [6:0]  opcode_ID,
    output logic [4:0]  rd_ID,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1_ID,
    output logic [4:0]  rs2_ID,
    output logic [6:0]  funct7,
    output logic        en,
    output logic        IF_flush_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        en_q, en_d;
    logic        flush_q, flush_d;
    logic        redirect;
    logic        load_resp;
    logic        capture;
    logic        release_hold;

    assign redirect = IF_flush | jump_ID;

    // A request still in flight across reset leaves us in DRAIN so its late response is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid) begin
                state_q <= DRAIN;
            end else begin
                state_q <= ISSUE;
            end
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE: state_d = redirect ? DRAIN : WAIT;
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? ISSUE : DRAIN;
                end else if (imem_rvalid) begin
                    state_d = stall ? HOLD : ISSUE;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // Priority is redirect, then stall, then response; the hold buffer only matters while in HOLD.
    always_comb begin
        imem_req     = rst_n && (state_q == ISSUE);
        imem_addr    = fetch_pc_q;
        load_resp    = (state_q == WAIT) && imem_rvalid && !redirect && !stall;
        capture      = (state_q == WAIT) && imem_rvalid && !redirect && stall;
        release_hold = (state_q == HOLD) && !redirect && !stall;

        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        if_pc_d      = if_pc_q;
        en_d         = en_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        flush_d      = redirect;

        if (redirect) begin
            fetch_pc_d = EA;
            en_d       = 1'b0;
            instr_d    = NOP_INSTR;
        end else if (load_resp) begin
            instr_d    = imem_rdata;
            if_pc_d    = fetch_pc_q;
            en_d       = 1'b1;
            fetch_pc_d = fetch_pc_q + STEP;
        end else if (release_hold) begin
            instr_d    = hold_instr_q;
            if_pc_d    = hold_pc_q;
            en_d       = 1'b1;
            fetch_pc_d = fetch_pc_q + STEP;
        end else if (capture) begin
            hold_pc_d    = fetch_pc_q;
            hold_instr_d = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            instr_q      <= NOP_INSTR;
            if_pc_q      <= 32'h0;
            en_q         <= 1'b0;
            flush_q      <= 1'b0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            if_pc_q      <= if_pc_d;
            en_q         <= en_d;
            flush_q      <= flush_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign IF_PC        = if_pc_q;
    assign opcode_ID    = instr_q[6:0];
    assign rd_ID        = instr_q[11:7];
    assign funct3       = instr_q[14:12];
    assign rs1_ID       = instr_q[19:15];
    assign rs2_ID       = instr_q[24:20];
    assign funct7       = instr_q[31:25];
    assign en           = en_q;
    assign IF_flush_out = flush_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        ifid_load;

    assign ifid_load = load_resp | release_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (ifid_load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redirect) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: startup vector table, directed redirect/reset/wrap
// sequences, then randomized traffic against a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall, IF_flush, jump_ID;
    logic [31:0] EA;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_PC;
    logic [6:0]  opcode_ID, funct7;
    logic [4:0]  rd_ID, rs1_ID, rs2_ID;
    logic [2:0]  funct3;
    logic        en, IF_flush_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .IF_flush(IF_flush), .jump_ID(jump_ID), .EA(EA),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_PC(IF_PC), .opcode_ID(opcode_ID), .rd_ID(rd_ID), .funct3(funct3), .rs1_ID(rs1_ID),
        .rs2_ID(rs2_ID), .funct7(funct7), .en(en), .IF_flush_out(IF_flush_out)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct {
        bit          st;
        bit          expReq;
        logic [31:0] expAddr;
        bit          expEn;
        logic [31:0] expPc;
        logic [31:0] expInstr;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: outstanding/stale/held flags instead of named states.
    bit          mOut, mStale, mHeld, mEn, mFlush;
    logic [31:0] mPc, mHpc, mHin, mInstr, mIfPc, mLoads, mRedirs;

    int          memLat = 2;
    int          memCnt = 0;
    logic [31:0] memAddr = 32'h0;
    bit          lastReq;
    logic [31:0] lastAddr;
    bit          checkEn = 1'b1;
    bit          tabActive = 1'b0;
    int          tabIdx;
    vec_t        vecs[14];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A3_0293;
        return a * 32'h9E37_79B1 + 32'd1;
    endfunction

    function automatic vec_t mkVec(bit st, bit rq, logic [31:0] ad, bit e, logic [31:0] pc, logic [31:0] ins);
        vec_t v;
        v.st = st; v.expReq = rq; v.expAddr = ad; v.expEn = e; v.expPc = pc; v.expInstr = ins;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dutInstr();
        return {funct7, rs2_ID, rs1_ID, funct3, rd_ID, opcode_ID};
    endfunction

    task modelLoad(input logic [31:0] pc, input logic [31:0] ins);
        mIfPc = pc; mInstr = ins; mEn = 1'b1;
        mPc = mPc + 32'd4;
        mLoads = mLoads + 32'd1;
    endtask

    task modelStep(input bit st, input bit redir, input logic [31:0] ea, input bit rn,
                   input bit rv, input logic [31:0] rd);
        bit req;
        req = rn && !mOut && !mHeld;
        if (!rn) begin
            if (rv) mOut = 1'b0;
            else if (mOut) mStale = 1'b1;
            mHeld = 1'b0; mPc = 32'h0; mEn = 1'b0; mInstr = NOP; mIfPc = 32'h0;
            mFlush = 1'b0; mLoads = 32'h0; mRedirs = 32'h0;
            return;
        end
        mFlush = redir;
        if (redir) begin
            mRedirs = mRedirs + 32'd1;
            mPc = ea; mEn = 1'b0; mInstr = NOP; mHeld = 1'b0;
            if (rv) mOut = 1'b0;
            else if (mOut || req) begin mOut = 1'b1; mStale = 1'b1; end
        end else begin
            if (mHeld) begin
                if (!st) begin modelLoad(mHpc, mHin); mHeld = 1'b0; end
            end else if (rv && mOut) begin
                mOut = 1'b0;
                if (!mStale) begin
                    if (st) begin mHeld = 1'b1; mHpc = mPc; mHin = rd; end
                    else modelLoad(mPc, rd);
                end
            end
            if (req) begin mOut = 1'b1; mStale = 1'b0; end
        end
    endtask

    task checkOutput();
        bit expReq;
        expReq = rst_n && !mOut && !mHeld;
        check("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) check("imem_addr", imem_addr, mPc);
        check("en", 32'(en), 32'(mEn));
        check("IF_flush_out", 32'(IF_flush_out), 32'(mFlush));
        check("instr fields", dutInstr(), mInstr);
        if (mEn) check("IF_PC", IF_PC, mIfPc);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, mLoads);
        check("flush_cnt", flush_cnt, mRedirs);
`endif
    endtask

    task tableCompare();
        vec_t v;
        v = vecs[tabIdx];
        check($sformatf("vec%0d req", tabIdx), 32'(imem_req), 32'(v.expReq));
        if (v.expReq) check($sformatf("vec%0d addr", tabIdx), imem_addr, v.expAddr);
        check($sformatf("vec%0d en", tabIdx), 32'(en), 32'(v.expEn));
        if (v.expEn) check($sformatf("vec%0d IF_PC", tabIdx), IF_PC, v.expPc);
        check($sformatf("vec%0d flush_out", tabIdx), 32'(IF_flush_out), 32'h0);
        check($sformatf("vec%0d opcode", tabIdx), 32'(opcode_ID), 32'(v.expInstr[6:0]));
        check($sformatf("vec%0d rd", tabIdx), 32'(rd_ID), 32'(v.expInstr[11:7]));
        check($sformatf("vec%0d funct3", tabIdx), 32'(funct3), 32'(v.expInstr[14:12]));
        check($sformatf("vec%0d rs1", tabIdx), 32'(rs1_ID), 32'(v.expInstr[19:15]));
        check($sformatf("vec%0d rs2", tabIdx), 32'(rs2_ID), 32'(v.expInstr[24:20]));
        check($sformatf("vec%0d funct7", tabIdx), 32'(funct7), 32'(v.expInstr[31:25]));
    endtask

    // One clock cycle: drive inputs, let the memory respond, compare, advance the model, cross the edge.
    task applyStimulus(input bit st, input bit fl, input bit jp, input logic [31:0] ea, input bit rn);
        stall = st; IF_flush = fl; jump_ID = jp; EA = ea; rst_n = rn;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (memCnt > 0) begin
            memCnt--;
            if (memCnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(memAddr);
            end
        end
        #1;
        if (checkEn) checkOutput();
        if (tabActive) tableCompare();
        lastReq  = imem_req;
        lastAddr = imem_addr;
        if (imem_req) begin
            memCnt  = memLat;
            memAddr = imem_addr;
        end
        modelStep(st, fl | jp, ea, rn, imem_rvalid, imem_rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input int maxCyc, input logic [31:0] expAddr, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            seen = lastReq;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: no imem_req within %0d cycles, expected addr %h", name, maxCyc, expAddr);
        end else begin
            check(name, lastAddr, expAddr);
        end
    endtask

    task automatic waitEn(input int maxCyc, input logic [31:0] expPc, input string name);
        for (int i = 0; i < maxCyc && !en; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check({name, " en"}, 32'(en), 32'h1);
        check({name, " IF_PC"}, IF_PC, expPc);
        check({name, " instr"}, dutInstr(), memWord(expPc));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; IF_flush = 1'b0; jump_ID = 1'b0; EA = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        mOut = 1'b0; mStale = 1'b0; mHeld = 1'b0; mEn = 1'b0; mFlush = 1'b0;
        mPc = 32'h0; mHpc = 32'h0; mHin = 32'h0; mInstr = NOP; mIfPc = 32'h0;
        mLoads = 32'h0; mRedirs = 32'h0;

        // Startup with a two-cycle-latency memory: ISSUE, WAIT, WAIT+response, then the load shows.
        vecs[0]  = mkVec(0, 1, 32'h0, 0, 32'h0, NOP);
        vecs[1]  = mkVec(0, 0, 32'h0, 0, 32'h0, NOP);
        vecs[2]  = mkVec(0, 0, 32'h0, 0, 32'h0, NOP);
        vecs[3]  = mkVec(0, 1, 32'h4, 1, 32'h0, memWord(32'h0));
        vecs[4]  = mkVec(0, 0, 32'h0, 1, 32'h0, memWord(32'h0));
        vecs[5]  = mkVec(0, 0, 32'h0, 1, 32'h0, memWord(32'h0));
        vecs[6]  = mkVec(0, 1, 32'h8, 1, 32'h4, memWord(32'h4));
        vecs[7]  = mkVec(0, 0, 32'h0, 1, 32'h4, memWord(32'h4));
        vecs[8]  = mkVec(1, 0, 32'h0, 1, 32'h4, memWord(32'h4));
        vecs[9]  = mkVec(1, 0, 32'h0, 1, 32'h4, memWord(32'h4));
        vecs[10] = mkVec(1, 0, 32'h0, 1, 32'h4, memWord(32'h4));
        vecs[11] = mkVec(1, 0, 32'h0, 1, 32'h4, memWord(32'h4));
        vecs[12] = mkVec(0, 0, 32'h0, 1, 32'h4, memWord(32'h4));
        vecs[13] = mkVec(0, 1, 32'hC, 1, 32'h8, memWord(32'h8));

        @(posedge clk);
        #1;
        checkEn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        memLat = 2;
        tabActive = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tabIdx = i;
            applyStimulus(vecs[i].st, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        tabActive = 1'b0;

        $display("[TB] flush while waiting on a 3-cycle memory");
        memLat = 3;
        waitReq(20, 32'h10, "seqA first req");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 1'b1);
        check("seqA flush_out pulse", 32'(IF_flush_out), 32'h1);
        check("seqA en cleared", 32'(en), 32'h0);
        check("seqA NOP presented", dutInstr(), NOP);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("seqA flush_out drops", 32'(IF_flush_out), 32'h0);
        check("seqA stale dropped", 32'(en), 32'h0);
        waitReq(20, 32'h100, "seqA redirect req");
        waitEn(20, 32'h100, "seqA load");

        $display("[TB] jump with stall on the response cycle");
        memLat = 2;
        waitReq(20, 32'h104, "seqB first req");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
        check("seqB en cleared", 32'(en), 32'h0);
        check("seqB flush_out", 32'(IF_flush_out), 32'h1);
        waitReq(20, 32'h200, "seqB redirect req");

        $display("[TB] reset with a request outstanding");
        memLat = 4;
        waitReq(20, 32'h204, "seqC first req");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("seqC en reset", 32'(en), 32'h0);
        check("seqC IF_PC reset", IF_PC, 32'h0);
        check("seqC flush_out reset", 32'(IF_flush_out), 32'h0);
        check("seqC instr reset", dutInstr(), NOP);
        check("seqC imem_req reset", 32'(imem_req), 32'h0);
        waitReq(20, 32'h0, "seqC req at RESET_PC");
        check("seqC late response ignored", 32'(en), 32'h0);

        $display("[TB] PC wrap at the top of the address space");
        memLat = 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1);
        waitReq(20, 32'hFFFF_FFFC, "seqD top req");
        waitReq(20, 32'h0, "seqD wrapped req");
        check("seqD IF_PC top", IF_PC, 32'hFFFF_FFFC);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            memLat = $urandom_range(1, 4);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 63) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
